// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR local-queue read/write arbiters: FSM encoding,
// beat-to-byte scaling and default watchdog limit.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_CPL = 2'd2
  } arb_state_e;

  // One beat is 8 bytes.
  localparam int unsigned BEAT_SHIFT         = 3;
  localparam int unsigned STRB_WIDTH         = 8;
  localparam int unsigned BYTES_WIDTH        = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/ddr_local_rd_arbiter_if.sv
// Request-side and DDR-command-side signals of the local read arbiter.
// slave = arbiter view, master = requesters + DDR read engine view.
interface ddr_local_rd_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int unsigned P_QUEUE_NUM        = 4,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned P_LEN_WIDTH        = 16
);

  logic [P_QUEUE_NUM-1:0]                    i_req_valid;
  logic [P_QUEUE_NUM*C_M_AXI_ADDR_WIDTH-1:0] i_req_addr;
  logic [P_QUEUE_NUM*P_LEN_WIDTH-1:0]        i_req_len;
  logic [P_QUEUE_NUM*STRB_WIDTH-1:0]         i_req_strb;
  logic [P_QUEUE_NUM-1:0]                    o_req_ready;
  logic [P_QUEUE_NUM-1:0]                    o_req_cpl;

  logic                          o_rd_ddr_valid;
  logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_ddr_addr;
  logic [P_LEN_WIDTH-1:0]        o_rd_ddr_len;
  logic [STRB_WIDTH-1:0]         o_rd_ddr_strb;
  logic                          i_rd_ddr_ready;
  logic                          i_rd_ddr_cpl;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_len, i_req_strb,
    input  i_rd_ddr_ready, i_rd_ddr_cpl,
    output o_req_ready, o_req_cpl,
    output o_rd_ddr_valid, o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_len, i_req_strb,
    output i_rd_ddr_ready, i_rd_ddr_cpl,
    input  o_req_ready, o_req_cpl,
    input  o_rd_ddr_valid, o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb
  );

endinterface

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request after i_last, wrapping.
// Shared by the read- and write-side DDR arbiters.
module rr_arbiter_comb #(
  parameter  int unsigned P_N = 4,
  localparam int unsigned IW  = $clog2(P_N)
) (
  input  logic [P_N-1:0] i_req,
  input  logic [IW-1:0]  i_last,
  output logic [IW-1:0]  o_grant,
  output logic           o_any_req
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    o_grant   = i_last;
    o_any_req = 1'b0;
    cand      = '0;
    for (int unsigned i = P_N; i >= 1; i--) begin
      cand = IW'((32'(i_last) + i) % P_N);
      if (i_req[cand]) begin
        o_grant   = cand;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_local_rd_arbiter.sv
// Shares one DDR read-command channel among P_QUEUE_NUM local queues, one read
// outstanding at a time. Optional completion watchdog under `DDR_RD_TIMEOUT_EN.
module ddr_local_rd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned P_QUEUE_NUM        = 4,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned P_LEN_WIDTH        = 16,
  parameter int unsigned P_TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  ddr_local_rd_arbiter_if.slave          bus,
  output logic [$clog2(P_QUEUE_NUM)-1:0] o_cur_grant,
  output logic                           o_busy,
  output logic [BYTES_WIDTH-1:0]         o_rd_bytes
`ifdef DDR_RD_TIMEOUT_EN
  ,
  output logic                           o_timeout_err
`endif
);

  localparam int unsigned QN = P_QUEUE_NUM;
  localparam int unsigned IW = $clog2(P_QUEUE_NUM);
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned LW = P_LEN_WIDTH;

  if (P_QUEUE_NUM < 2 || P_QUEUE_NUM > 16 || P_TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ddr_local_rd_arbiter: unsupported parameter set");
  end

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [LW-1:0]           len_q, len_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [QN-1:0]           ready_q, ready_d;
  logic [QN-1:0]           cpl_q, cpl_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [BYTES_WIDTH-1:0]  bytes_q, bytes_d;
`ifdef DDR_RD_TIMEOUT_EN
  logic [31:0]             wdog_q, wdog_d;
  logic                    tmo_q, tmo_d;
`endif

  logic [IW-1:0] win_c;
  logic          any_c;
  logic [LW-1:0] win_len_c;

  function automatic logic [QN-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // A zero-length grant returns to IDLE while its requester still sees ready;
  // masking that queue for one cycle prevents re-granting the stale descriptor.
  rr_arbiter_comb #(.P_N(QN)) u_rr (
    .i_req     (bus.i_req_valid & ~ready_q),
    .i_last    (ptr_q),
    .o_grant   (win_c),
    .o_any_req (any_c)
  );

  assign win_len_c = bus.i_req_len[win_c*LW +: LW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    strb_d  = strb_q;
    ready_d = '0;
    cpl_d   = '0;
    valid_d = valid_q;
    bytes_d = bytes_q;
`ifdef DDR_RD_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          grant_d = win_c;
          addr_d  = bus.i_req_addr[win_c*AW +: AW];
          len_d   = win_len_c;
          strb_d  = bus.i_req_strb[win_c*STRB_WIDTH +: STRB_WIDTH];
          ready_d = onehot(win_c);
          if (win_len_c != '0) begin
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            cpl_d = onehot(win_c);
            ptr_d = win_c;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.i_rd_ddr_ready) begin
          valid_d = 1'b0;
          state_d = ST_WAIT_CPL;
`ifdef DDR_RD_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end

      ST_WAIT_CPL: begin
        if (bus.i_rd_ddr_cpl) begin
          cpl_d   = onehot(grant_q);
          bytes_d = bytes_q + (BYTES_WIDTH'(len_q) << BEAT_SHIFT);
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
`ifdef DDR_RD_TIMEOUT_EN
        else if (wdog_q == 32'(P_TIMEOUT_CYCLES - 1)) begin
          cpl_d   = onehot(grant_q);
          tmo_d   = 1'b1;
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(QN - 1);
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      strb_q  <= '0;
      ready_q <= '0;
      cpl_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      bytes_q <= '0;
`ifdef DDR_RD_TIMEOUT_EN
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      strb_q  <= strb_d;
      ready_q <= ready_d;
      cpl_q   <= cpl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      bytes_q <= bytes_d;
`ifdef DDR_RD_TIMEOUT_EN
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.o_req_ready    = ready_q;
  assign bus.o_req_cpl      = cpl_q;
  assign bus.o_rd_ddr_valid = valid_q;
  assign bus.o_rd_ddr_addr  = addr_q;
  assign bus.o_rd_ddr_len   = len_q;
  assign bus.o_rd_ddr_strb  = strb_q;
  assign o_cur_grant        = grant_q;
  assign o_busy             = busy_q;
  assign o_rd_bytes         = bytes_q;
`ifdef DDR_RD_TIMEOUT_EN
  assign o_timeout_err      = tmo_q;
`endif

endmodule

// File: tb/tb_ddr_local_rd_arbiter.sv
// Self-checking bench for ddr_local_rd_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin / byte-count model.
module tb_ddr_local_rd_arbiter;
  import ddr_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cur_grant;
  logic        busy;
  logic [31:0] rd_bytes;
`ifdef DDR_RD_TIMEOUT_EN
  logic        tmo_err;
`endif

  always #5 clk = ~clk;

  ddr_local_rd_arbiter_if #(.P_QUEUE_NUM(N), .C_M_AXI_ADDR_WIDTH(AW), .P_LEN_WIDTH(LW)) bus ();

  ddr_local_rd_arbiter #(
    .P_QUEUE_NUM(N), .C_M_AXI_ADDR_WIDTH(AW), .P_LEN_WIDTH(LW), .P_TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus),
    .o_cur_grant  (cur_grant),
    .o_busy       (busy),
`ifdef DDR_RD_TIMEOUT_EN
    .o_timeout_err(tmo_err),
`endif
    .o_rd_bytes   (rd_bytes)
  );

  int total = 0;
  int bad   = 0;

  // Requester-side descriptors and reference state.
  logic [N-1:0]  vld;
  logic [AW-1:0] addr [N];
  logic [LW-1:0] len  [N];
  logic [7:0]    strb [N];
  int            ptr;
  logic [31:0]   exp_bytes;
  bit            allow_zero;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int i = 1; i <= int'(N); i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic apply();
    for (int q = 0; q < int'(N); q++) begin
      bus.i_req_addr[q*AW +: AW] = addr[q];
      bus.i_req_len[q*LW +: LW]  = len[q];
      bus.i_req_strb[q*8 +: 8]   = strb[q];
    end
    bus.i_req_valid = vld;
  endtask

  task automatic new_desc(input int q);
    addr[q] = $urandom() & 32'hFFFF_FFF8;
    if (allow_zero && $urandom_range(7) == 0) len[q] = '0;
    else len[q] = LW'($urandom_range(1, 300));
    strb[q] = 8'($urandom());
    vld[q]  = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_rd_ddr_ready = 1'b0;
    bus.i_rd_ddr_cpl   = 1'b0;
    vld = '0;
    apply();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    ptr       = N - 1;
    exp_bytes = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, bus.o_req_ready, 0);
    chk({tag, "_cpl"},   bus.o_req_cpl, 0);
    chk({tag, "_valid"}, bus.o_rd_ddr_valid, 0);
    chk({tag, "_addr"},  bus.o_rd_ddr_addr, 0);
    chk({tag, "_len"},   bus.o_rd_ddr_len, 0);
    chk({tag, "_strb"},  bus.o_rd_ddr_strb, 0);
    chk({tag, "_grant"}, cur_grant, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_bytes"}, rd_bytes, 0);
  endtask

  // One grant/issue/completion, checked against the round-robin model.
  task automatic do_txn(input int bp, input int cpl_dly, input bit rep, input bit raise,
                        input bit cpl_in_issue, input bit withhold,
                        output int g, output int lat);
    int e;
    bit got;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_len;
    logic [7:0]    d_strb;
    if (vld == '0) new_desc($urandom_range(N - 1));
    apply();
    e = rr_pick(ptr, vld);
    g = e;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.o_req_ready != '0) begin
        got = 1'b1;
        lat = c;
      end else begin
        chk("no_spurious_cpl", bus.o_req_cpl, 0);
      end
    end
    chk("ready_seen", 64'(got), 1);
    if (!got) return;
    chk("ready_onehot", bus.o_req_ready, 64'(1) << e);
    chk("cur_grant", cur_grant, e);
    d_addr = addr[e];
    d_len  = len[e];
    d_strb = strb[e];
    if (rep) new_desc(e); else vld[e] = 1'b0;
    if (raise)
      for (int q = 0; q < int'(N); q++)
        if (!vld[q] && $urandom_range(1) == 1) new_desc(q);
    apply();
    ptr = e;

    if (d_len == '0) begin
      chk("zlen_cpl", bus.o_req_cpl, 64'(1) << e);
      chk("zlen_no_ddr_valid", bus.o_rd_ddr_valid, 0);
      chk("zlen_bytes", rd_bytes, exp_bytes);
      return;
    end

    chk("ddr_valid", bus.o_rd_ddr_valid, 1);
    chk("ddr_addr", bus.o_rd_ddr_addr, d_addr);
    chk("ddr_len", bus.o_rd_ddr_len, d_len);
    chk("ddr_strb", bus.o_rd_ddr_strb, d_strb);
    chk("busy_issue", busy, 1);
    bus.i_rd_ddr_ready = (bp == 0);
    for (int c = 0; c < bp; c++) begin
      bus.i_rd_ddr_cpl = cpl_in_issue && (c == 0);
      @(negedge clk);
      bus.i_rd_ddr_cpl = 1'b0;
      chk("bp_valid", bus.o_rd_ddr_valid, 1);
      chk("bp_addr", bus.o_rd_ddr_addr, d_addr);
      chk("bp_len", bus.o_rd_ddr_len, d_len);
      chk("bp_strb", bus.o_rd_ddr_strb, d_strb);
      chk("bp_ready_single", bus.o_req_ready, 0);
      chk("bp_no_cpl", bus.o_req_cpl, 0);
    end
    bus.i_rd_ddr_ready = 1'b1;
    bus.i_rd_ddr_cpl   = cpl_in_issue;
    @(negedge clk);
    bus.i_rd_ddr_ready = 1'b0;
    bus.i_rd_ddr_cpl   = 1'b0;
    chk("hs_valid_drop", bus.o_rd_ddr_valid, 0);
    chk("hs_no_cpl", bus.o_req_cpl, 0);
    chk("hs_ready_single", bus.o_req_ready, 0);
    chk("hs_busy", busy, 1);

    if (withhold) begin
`ifdef DDR_RD_TIMEOUT_EN
      int cnt;
      cnt = 0;
      chk("tmo_err_clear", tmo_err, 0);
      for (int n = 1; n <= 200 && cnt == 0; n++) begin
        @(negedge clk);
        if (bus.o_req_cpl != '0) cnt = n;
      end
      chk("tmo_cycles", cnt, TMO);
      chk("tmo_cpl", bus.o_req_cpl, 64'(1) << e);
      chk("tmo_err_set", tmo_err, 1);
      chk("tmo_bytes", rd_bytes, exp_bytes);
      bus.i_rd_ddr_cpl = 1'b1;
      @(negedge clk);
      bus.i_rd_ddr_cpl = 1'b0;
      @(negedge clk);
      chk("tmo_late_cpl", bus.o_req_cpl, 0);
      chk("tmo_late_bytes", rd_bytes, exp_bytes);
      chk("tmo_err_sticky", tmo_err, 1);
`endif
      return;
    end

    for (int c = 0; c < cpl_dly; c++) begin
      @(negedge clk);
      chk("wait_no_cpl", bus.o_req_cpl, 0);
    end
    bus.i_rd_ddr_cpl = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_cpl = 1'b0;
    exp_bytes = exp_bytes + (32'(d_len) << 3);
    chk("cpl_onehot", bus.o_req_cpl, 64'(1) << e);
    chk("rd_bytes", rd_bytes, exp_bytes);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    int g, lat;
    int order [5] = '{0, 1, 2, 3, 0};
    allow_zero = 1'b0;
    bus.i_rd_ddr_ready = 1'b0;
    bus.i_rd_ddr_cpl   = 1'b0;
    for (int q = 0; q < int'(N); q++) begin
      addr[q] = '0; len[q] = '0; strb[q] = '0;
    end
    vld = '0;
    apply();

    // Reset state
    #2;
    check_all_zero("reset");
    do_reset();

    // Single request from queue 2
    addr[2] = 32'h1000; len[2] = 16; strb[2] = 8'hFF; vld[2] = 1'b1;
    do_txn(0, 4, 0, 0, 0, 0, g, lat);
    chk("t1_grant", g, 2);
    chk("t1_latency", lat, 1);
    chk("t1_bytes", rd_bytes, 128);

    // All queues continuously valid
    do_reset();
    for (int q = 0; q < int'(N); q++) new_desc(q);
    for (int i = 0; i < 5; i++) begin
      do_txn(0, $urandom_range(3), 1, 0, 0, 0, g, lat);
      chk("t2_order", g, order[i]);
    end

    // DDR backpressure, with stray cpl in ISSUE and at the handshake
    vld = '0;
    new_desc(3);
    do_txn(10, 2, 0, 0, 1, 0, g, lat);

    // Zero-length request
    vld = '0;
    apply();
    @(negedge clk);
    new_desc(1);
    len[1] = '0;
    do_txn(0, 0, 0, 0, 0, 0, g, lat);
    chk("t4_grant", g, 1);
    new_desc(0); new_desc(2);
    do_txn(0, 1, 0, 0, 0, 0, g, lat);
    chk("t4_next", g, 2);

    // Completion pulse while idle is ignored
    vld = '0;
    apply();
    repeat (2) @(negedge clk);
    bus.i_rd_ddr_cpl = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_cpl = 1'b0;
    @(negedge clk);
    chk("idle_cpl_ignored", bus.o_req_cpl, 0);
    chk("idle_cpl_bytes", rd_bytes, exp_bytes);

    // Randomized traffic
    allow_zero = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int bp;
      bp = $urandom_range(3);
      do_txn(bp, $urandom_range(4), 1'($urandom_range(1)), 1'($urandom_range(1)),
             (bp > 0) && ($urandom_range(1) == 1), 0, g, lat);
    end
    allow_zero = 1'b0;

    // Reset mid-transfer (in WAIT_CPL)
    do_reset();
    new_desc(2);
    do_txn(0, 0, 0, 0, 0, 0, g, lat);
    vld = '0;
    new_desc(1); new_desc(2);
    apply();
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.o_req_ready != '0) lat = c;
    end
    chk("t5_ready", bus.o_req_ready, 4'b0010);
    vld[1] = 1'b0;
    apply();
    bus.i_rd_ddr_ready = 1'b1;
    @(negedge clk);
    bus.i_rd_ddr_ready = 1'b0;
    chk("t5_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    rst_n     = 1'b1;
    ptr       = N - 1;
    exp_bytes = '0;
    new_desc(0);
    do_txn(0, 1, 0, 0, 0, 0, g, lat);
    chk("t5_first_grant", g, 0);

`ifdef DDR_RD_TIMEOUT_EN
    // Completion watchdog
    do_reset();
    new_desc(3);
    do_txn(0, 0, 0, 0, 0, 1, g, lat);
    chk("t6_grant", g, 3);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
